// File: rtl/dphy_delay_calib.sv
// dphy_delay_calib: per-lane IDELAY tap calibration for the D-PHY receive path.
// Sweeps taps 0..31 on all lanes together. At each tap it counts header good/bad
// indications, tracks the longest passing tap run per lane, and loads the centre
// of that run as the final delay.
// Optional feature: define DPHY_DELAY_CALIB_STATS_EN to add eye_width_o, which
// reports the winning run length per lane.
module dphy_delay_calib #(
  parameter int DATA_LANES   = 2,
  parameter int SETTLE_TICKS = 64,
  parameter int WINDOW_TICKS = 4096,
  parameter int MIN_OK       = 2,
  parameter int DEFAULT_TAP  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [DATA_LANES-1:0]      sync_ok_i,
  input  logic [DATA_LANES-1:0]      sync_err_i,
  output logic                       delay_act_o,
  output logic [DATA_LANES-1:0][4:0] lane_delay_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [DATA_LANES-1:0]      fail_o
`ifdef DPHY_DELAY_CALIB_STATS_EN
  ,
  output logic [DATA_LANES-1:0][5:0] eye_width_o
`endif
);

  localparam int TICK_MAX = (SETTLE_TICKS > WINDOW_TICKS) ? SETTLE_TICKS : WINDOW_TICKS;
  localparam int TW       = $clog2(TICK_MAX + 1);

  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_TICKS - 1);
  localparam logic [TW-1:0] WINDOW_LAST = TW'(WINDOW_TICKS - 1);
  localparam logic [4:0]    DEF_TAP     = 5'(DEFAULT_TAP);
  localparam logic [15:0]   MIN_OK_W    = 16'(MIN_OK);
  localparam logic [4:0]    LAST_TAP    = 5'd31;
  localparam logic [15:0]   CNT_MAX     = 16'hFFFF;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    ACT,
    SETTLE,
    MEASURE,
    EVAL,
    APPLY,
    APPLY_ACT,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [4:0]    tap;
  logic [TW-1:0] tick;
  logic          start_accept;
  logic          tap_is_last;

  logic [DATA_LANES-1:0][15:0] ok_cnt;
  logic [DATA_LANES-1:0][15:0] err_cnt;

  logic [DATA_LANES-1:0][4:0] cur_start;
  logic [DATA_LANES-1:0][5:0] cur_len;
  logic [DATA_LANES-1:0][4:0] best_start;
  logic [DATA_LANES-1:0][5:0] best_len;

  logic [DATA_LANES-1:0]      tap_pass;
  logic [DATA_LANES-1:0][4:0] run_start;
  logic [DATA_LANES-1:0][5:0] run_len;
  logic [DATA_LANES-1:0][4:0] centre;

  assign start_accept = (state == IDLE) && start_i;
  assign tap_is_last  = (tap == LAST_TAP);

  // State register; reset returns straight to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and strobe decode; all outputs here are functions of the state.
  always_comb begin
    state_next  = state;
    delay_act_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        busy_o     = 1'b1;
        state_next = ACT;
      end
      ACT: begin
        busy_o      = 1'b1;
        delay_act_o = 1'b1;
        state_next  = SETTLE;
      end
      SETTLE: begin
        busy_o = 1'b1;
        if (tick == SETTLE_LAST) begin
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        busy_o = 1'b1;
        if (tick == WINDOW_LAST) begin
          state_next = EVAL;
        end
      end
      EVAL: begin
        busy_o     = 1'b1;
        state_next = tap_is_last ? APPLY : LOAD;
      end
      APPLY: begin
        busy_o     = 1'b1;
        state_next = APPLY_ACT;
      end
      APPLY_ACT: begin
        busy_o      = 1'b1;
        delay_act_o = 1'b1;
        state_next  = DONE;
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Cycle counter for the settle and measurement phases; restarts on every state change.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick <= '0;
    end else if ((state_next != state) || !((state == SETTLE) || (state == MEASURE))) begin
      tick <= '0;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  // Tap sweep counter: cleared on start, advanced after each evaluation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tap <= '0;
    end else if (start_accept) begin
      tap <= '0;
    end else if ((state == EVAL) && !tap_is_last) begin
      tap <= tap + 5'd1;
    end
  end

  // Per-lane good/bad counters: held clear while settling, saturating count in the window.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else if (state == SETTLE) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else if (state == MEASURE) begin
      for (int l = 0; l < DATA_LANES; l++) begin
        if (sync_ok_i[l] && (ok_cnt[l] != CNT_MAX)) begin
          ok_cnt[l] <= ok_cnt[l] + 16'd1;
        end
        if (sync_err_i[l] && (err_cnt[l] != CNT_MAX)) begin
          err_cnt[l] <= err_cnt[l] + 16'd1;
        end
      end
    end
  end

  // Per-lane pass decision, run extension and centre of the best run.
  always_comb begin
    tap_pass  = '0;
    run_start = '0;
    run_len   = '0;
    centre    = '0;
    for (int l = 0; l < DATA_LANES; l++) begin
      tap_pass[l]  = (ok_cnt[l] >= MIN_OK_W) && (err_cnt[l] == 16'd0);
      run_start[l] = (cur_len[l] == 6'd0) ? tap : cur_start[l];
      run_len[l]   = cur_len[l] + 6'd1;
      centre[l]    = best_start[l] + 5'((best_len[l] - 6'd1) >> 1);
    end
  end

  // Run trackers: a passing tap extends the current run, a strictly longer run replaces the best.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_accept) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (state == EVAL) begin
      for (int l = 0; l < DATA_LANES; l++) begin
        if (tap_pass[l]) begin
          cur_start[l] <= run_start[l];
          cur_len[l]   <= run_len[l];
          if (run_len[l] > best_len[l]) begin
            best_start[l] <= run_start[l];
            best_len[l]   <= run_len[l];
          end
        end else begin
          cur_len[l] <= 6'd0;
        end
      end
    end
  end

  // Lane delay and fail flags: sweep value ahead of each LOAD, final centre in APPLY.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int l = 0; l < DATA_LANES; l++) begin
        lane_delay_o[l] <= DEF_TAP;
      end
      fail_o <= '0;
    end else if (start_accept) begin
      lane_delay_o <= '0;
      fail_o       <= '0;
    end else if ((state == EVAL) && !tap_is_last) begin
      for (int l = 0; l < DATA_LANES; l++) begin
        lane_delay_o[l] <= tap + 5'd1;
      end
    end else if (state == APPLY) begin
      for (int l = 0; l < DATA_LANES; l++) begin
        if (best_len[l] != 6'd0) begin
          lane_delay_o[l] <= centre[l];
        end else begin
          lane_delay_o[l] <= DEF_TAP;
          fail_o[l]       <= 1'b1;
        end
      end
    end
  end

`ifdef DPHY_DELAY_CALIB_STATS_EN
  // Eye width report: cleared on start, captured from the best run length in APPLY.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_accept) begin
      eye_width_o <= '0;
    end else if (state == APPLY) begin
      eye_width_o <= best_len;
    end
  end
`endif

endmodule
